alu_issue: RTL and testbench
============================

# alu_issue

Multi-cycle issue/collect unit that drives the `ALU` from the instruction side. It accepts one RV32I instruction plus register operands over a valid/ready handshake and decodes it into an ALU op code and operands. It holds those ALU inputs stable for a programmable number of cycles, then captures `C`/`f` and offers the result to writeback over a second valid/ready handshake. It sits between the register-read stage and the `ALU` in mySoC, and every op code it emits is drawn from the `ALU_OP_*` macros in `defines.vh`.

## Interface
- `EXEC_CYCLES`, default 1: cycles ALU inputs are held before capture; legal range 1..15.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_valid`  in  1  instruction offered.
- `inst_ready`  out  1  unit can accept an instruction.
- `inst`  in  32  RV32I instruction word.
- `rs1_data`  in  32  rs1 value, sampled with `inst`.
- `rs2_data`  in  32  rs2 value, sampled with `inst`.
- `alu_a`  out  32  to ALU `A`.
- `alu_b`  out  32  to ALU `B`.
- `alu_op`  out  4  to ALU `op`.
- `alu_c`  in  32  from ALU `C`.
- `alu_f`  in  1  from ALU `f`.
- `res_valid`  out  1  result offered.
- `res_ready`  in  1  writeback accepts the result.
- `res_data`  out  32  captured `alu_c`, or 0 for branch/illegal.
- `res_rd`  out  5  destination register, `inst[11:7]`.
- `res_we`  out  1  register write enable.
- `res_taken`  out  1  branch taken, captured `alu_f`.
- `res_illegal`  out  1  instruction not decodable.
- `retire_cnt`  out  32  count of completed result handshakes.

## Operation
- FSM states are IDLE, EXEC and HOLD. Reset enters IDLE.
- **IDLE:** `inst_ready`=1. When `inst_valid`&&`inst_ready` at an edge, the unit registers `inst`, `rs1_data` and `rs2_data` and loads the wait counter with `EXEC_CYCLES-1`.
  - A legal instruction moves the FSM to EXEC.
  - An illegal instruction moves the FSM straight to HOLD with `res_illegal`=1, `res_we`=0 and `res_data`=0.
- **EXEC:** `alu_a`, `alu_b` and `alu_op` are driven from the registered decode and held constant. The counter decrements each cycle. At the edge where the counter is 0, the unit captures `alu_c` and `alu_f` into the result registers and moves to HOLD.
- **HOLD:** `res_valid`=1 and all `res_*` outputs are stable. On `res_valid`&&`res_ready`, the unit increments `retire_cnt` (mod 2^32) and returns to IDLE.
- In IDLE and HOLD, `alu_a`, `alu_b` and `alu_op` are all zero.
- Decode, where immI is `inst[31:20]` sign-extended to 32 bits:
  - **R-type (opcode 0110011):**
    - add → `ALU_OP_ADD`; sub → `ALU_OP_SUB`.
    - and, or, xor → `ALU_OP_AND`, `ALU_OP_OR`, `ALU_OP_XOR`.
    - sll, srl, sra → `ALU_OP_SLL`, `ALU_OP_SLR`, `ALU_OP_SAR`.
    - A=rs1, B=rs2.
  - **I-type ALU (opcode 0010011):**
    - addi → `ALU_OP_ADD` with B=immI.
    - andi, ori, xori use B=immI.
    - slli, srli, srai use B={27'b0, shamt}.
    - A=rs1 for all.
  - **lui (opcode 0110111):** `ALU_OP_ADD`, A=0, B={inst[31:12], 12'b0}.
  - **Branch (opcode 1100011):**
    - beq, bne, blt, bge use the matching `ALU_OP_SUBOP`-family code from `defines.vh`.
    - A=rs1, B=rs2.
    - `res_we`=0, `res_data`=0, `res_taken`=captured `alu_f`.
  - **Everything else is illegal.** This includes funct7 values other than 0000000/0100000 on R-type and shifts, and the slt/sltu variants.
- `res_we`=1 only for legal non-branch instructions with rd≠0. `res_taken`=0 for non-branches.

## Timing
- Accept at edge k → EXEC occupies cycles k+1 … k+`EXEC_CYCLES` → capture at edge k+`EXEC_CYCLES` → `res_valid` is high from that edge.
- Illegal instruction: `res_valid` is high from edge k+1.
- There is no bypass. `inst_ready` goes high one cycle after the result handshake, so peak throughput is one instruction per `EXEC_CYCLES`+2 cycles.
- `inst_ready` is a registered state decode and never depends combinationally on `inst_valid` or `res_ready`.
- If `res_ready` is held 0, the unit stays in HOLD indefinitely with outputs unchanged.
- Changes to `inst`, `rs1_data` or `rs2_data` while not in IDLE have no effect.
- `rst` asserted in any state forces immediate IDLE. The pending instruction is dropped.
- Reset values:
  - `inst_ready`=0 while `rst` is high and 1 from the first cycle after release.
  - `res_valid`=0, `res_*`=0, `alu_a`/`alu_b`/`alu_op`=0, `retire_cnt`=0.
- `retire_cnt` wraps 0xFFFFFFFF→0.

## Test plan
- **addi x5,x1,-1:** rs1=5, `EXEC_CYCLES`=1.
  - One EXEC cycle with `alu_op`=`ALU_OP_ADD` and `alu_b`=0xFFFFFFFF.
  - Then `res_data`=4, `res_rd`=5, `res_we`=1, `retire_cnt`=1 after the handshake.
- **beq and bne with rs1=rs2=7:**
  - beq → `res_taken`=1, `res_we`=0.
  - bne → `res_taken`=0.
- **sra with rs1=0x80000000, rs2=4, `EXEC_CYCLES`=3:**
  - ALU inputs are held for 3 cycles.
  - `res_data`=0xF8000000, with `res_valid` first seen 3 cycles after accept.
- **Backpressure:** hold `res_ready`=0 for 10 cycles.
  - `res_*` are stable and `inst_ready`=0 throughout.
  - `inst_ready`=1 the cycle after `res_ready`=1.
- **Illegal word 0xFFFFFFFF:**
  - `res_valid` one cycle after accept, `res_illegal`=1, `res_we`=0.
  - The ALU inputs never leave zero.
- **Reset mid-EXEC, and counter wrap:**
  - Assert `rst` during EXEC → outputs zero immediately, and no result is produced after release.
  - Force `retire_cnt` to 0xFFFFFFFF, then complete one instruction → `retire_cnt`=0.

Source files
------------

// File: rtl/alu_issue.sv
// Issue/collect wrapper around the ALU: decodes one RV32I instruction, holds ALU inputs
// for EXEC_CYCLES cycles, captures C/f and offers the result to writeback.
module alu_issue #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_c,
  input  logic        alu_f,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_we,
  output logic        res_taken,
  output logic        res_illegal,
  output logic [31:0] retire_cnt
);
  // Op encoding mirrors the ALU_OP_* values in defines.vh
  localparam logic [3:0] ALU_OP_ADD       = 4'd0;
  localparam logic [3:0] ALU_OP_SUB       = 4'd1;
  localparam logic [3:0] ALU_OP_AND       = 4'd2;
  localparam logic [3:0] ALU_OP_OR        = 4'd3;
  localparam logic [3:0] ALU_OP_XOR       = 4'd4;
  localparam logic [3:0] ALU_OP_SLL       = 4'd5;
  localparam logic [3:0] ALU_OP_SLR       = 4'd6;
  localparam logic [3:0] ALU_OP_SAR       = 4'd7;
  localparam logic [3:0] ALU_OP_SUBOP_BEQ = 4'd8;
  localparam logic [3:0] ALU_OP_SUBOP_BNE = 4'd9;
  localparam logic [3:0] ALU_OP_SUBOP_BLT = 4'd10;
  localparam logic [3:0] ALU_OP_SUBOP_BGE = 4'd11;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic        branch_q, branch_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_data_q, res_data_d;
  logic [4:0]  res_rd_q, res_rd_d;
  logic        res_we_q, res_we_d;
  logic        res_taken_q, res_taken_d;
  logic        res_illegal_q, res_illegal_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic        dec_legal, dec_branch;
  logic [3:0]  dec_op;
  logic [31:0] dec_a, dec_b;
  logic        accept;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign accept = (state_q == IDLE) && ready_q && inst_valid;

  always_comb begin
    dec_legal  = 1'b0;
    dec_branch = 1'b0;
    dec_op     = ALU_OP_ADD;
    dec_a      = rs1_data;
    dec_b      = rs2_data;
    case (opcode)
      7'b0110011: begin
        case ({funct7, funct3})
          {7'h00, 3'h0}: begin dec_legal = 1'b1; dec_op = ALU_OP_ADD; end
          {7'h20, 3'h0}: begin dec_legal = 1'b1; dec_op = ALU_OP_SUB; end
          {7'h00, 3'h7}: begin dec_legal = 1'b1; dec_op = ALU_OP_AND; end
          {7'h00, 3'h6}: begin dec_legal = 1'b1; dec_op = ALU_OP_OR;  end
          {7'h00, 3'h4}: begin dec_legal = 1'b1; dec_op = ALU_OP_XOR; end
          {7'h00, 3'h1}: begin dec_legal = 1'b1; dec_op = ALU_OP_SLL; end
          {7'h00, 3'h5}: begin dec_legal = 1'b1; dec_op = ALU_OP_SLR; end
          {7'h20, 3'h5}: begin dec_legal = 1'b1; dec_op = ALU_OP_SAR; end
          default: ;
        endcase
      end
      7'b0010011: begin
        dec_b = imm_i;
        case (funct3)
          3'h0: begin dec_legal = 1'b1; dec_op = ALU_OP_ADD; end
          3'h4: begin dec_legal = 1'b1; dec_op = ALU_OP_XOR; end
          3'h6: begin dec_legal = 1'b1; dec_op = ALU_OP_OR;  end
          3'h7: begin dec_legal = 1'b1; dec_op = ALU_OP_AND; end
          3'h1: begin
            dec_b = {27'b0, inst[24:20]};
            if (funct7 == 7'h00) begin dec_legal = 1'b1; dec_op = ALU_OP_SLL; end
          end
          3'h5: begin
            dec_b = {27'b0, inst[24:20]};
            if (funct7 == 7'h00) begin dec_legal = 1'b1; dec_op = ALU_OP_SLR; end
            else if (funct7 == 7'h20) begin dec_legal = 1'b1; dec_op = ALU_OP_SAR; end
          end
          default: ;
        endcase
      end
      7'b0110111: begin
        dec_legal = 1'b1;
        dec_op    = ALU_OP_ADD;
        dec_a     = 32'd0;
        dec_b     = {inst[31:12], 12'b0};
      end
      7'b1100011: begin
        dec_branch = 1'b1;
        case (funct3)
          3'h0: begin dec_legal = 1'b1; dec_op = ALU_OP_SUBOP_BEQ; end
          3'h1: begin dec_legal = 1'b1; dec_op = ALU_OP_SUBOP_BNE; end
          3'h4: begin dec_legal = 1'b1; dec_op = ALU_OP_SUBOP_BLT; end
          3'h5: begin dec_legal = 1'b1; dec_op = ALU_OP_SUBOP_BGE; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      cnt_q         <= 4'd0;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      op_q          <= 4'd0;
      branch_q      <= 1'b0;
      we_q          <= 1'b0;
      rd_q          <= 5'd0;
      res_data_q    <= 32'd0;
      res_rd_q      <= 5'd0;
      res_we_q      <= 1'b0;
      res_taken_q   <= 1'b0;
      res_illegal_q <= 1'b0;
      retire_cnt_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      cnt_q         <= cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      branch_q      <= branch_d;
      we_q          <= we_d;
      rd_q          <= rd_d;
      res_data_q    <= res_data_d;
      res_rd_q      <= res_rd_d;
      res_we_q      <= res_we_d;
      res_taken_q   <= res_taken_d;
      res_illegal_q <= res_illegal_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    branch_d      = branch_q;
    we_d          = we_q;
    rd_d          = rd_q;
    res_data_d    = res_data_q;
    res_rd_d      = res_rd_q;
    res_we_d      = res_we_q;
    res_taken_d   = res_taken_q;
    res_illegal_d = res_illegal_q;
    retire_cnt_d  = retire_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = dec_a;
          b_d      = dec_b;
          op_d     = dec_op;
          branch_d = dec_branch;
          rd_d     = inst[11:7];
          we_d     = dec_legal && !dec_branch && (inst[11:7] != 5'd0);
          cnt_d    = CNT_LOAD;
          if (dec_legal) begin
            state_d = EXEC;
          end else begin
            // Illegal words skip the ALU entirely and report straight away
            state_d       = HOLD;
            res_data_d    = 32'd0;
            res_rd_d      = inst[11:7];
            res_we_d      = 1'b0;
            res_taken_d   = 1'b0;
            res_illegal_d = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d       = HOLD;
          res_data_d    = branch_q ? 32'd0 : alu_c;
          res_rd_d      = rd_q;
          res_we_d      = we_q;
          res_taken_d   = branch_q & alu_f;
          res_illegal_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_d      = IDLE;
          retire_cnt_d = retire_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_comb begin
    inst_ready  = ready_q;
    res_valid   = (state_q == HOLD);
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    alu_op      = 4'd0;
    if (state_q == EXEC) begin
      alu_a  = a_q;
      alu_b  = b_q;
      alu_op = op_q;
    end
    res_data    = res_data_q;
    res_rd      = res_rd_q;
    res_we      = res_we_q;
    res_taken   = res_taken_q;
    res_illegal = res_illegal_q;
    retire_cnt  = retire_cnt_q;
  end
endmodule

// File: tb/tb_alu_issue.sv
// Runs two alu_issue instances (EXEC_CYCLES 1 and 3) in lockstep against an ALU model
// and an instruction-level reference model.
module tb_alu_issue;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SLR = 4'd6, OP_SAR = 4'd7,
                         OP_BEQ = 4'd8, OP_BNE = 4'd9, OP_BLT = 4'd10, OP_BGE = 4'd11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [31:0] inst = 32'd0, rs1_data = 32'd0, rs2_data = 32'd0;

  logic        inst_ready_w[2];
  logic [31:0] alu_a_w[2], alu_b_w[2], alu_c_w[2];
  logic [3:0]  alu_op_w[2];
  logic        alu_f_w[2];
  logic        res_valid_w[2], res_we_w[2], res_taken_w[2], res_illegal_w[2];
  logic [31:0] res_data_w[2], retire_w[2];
  logic [4:0]  res_rd_w[2];

  int          tests = 0;
  int          failed = 0;
  logic [31:0] exp_retire = 32'd0;

  typedef struct packed {
    logic        legal;
    logic        branch;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        we;
    logic        taken;
    logic [4:0]  rd;
  } exp_t;

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] c;
    logic        f;
    c = 32'd0;
    f = 1'b0;
    case (op)
      OP_ADD: c = a + b;
      OP_SUB: c = a - b;
      OP_AND: c = a & b;
      OP_OR:  c = a | b;
      OP_XOR: c = a ^ b;
      OP_SLL: c = a << b[4:0];
      OP_SLR: c = a >> b[4:0];
      OP_SAR: c = $signed(a) >>> b[4:0];
      OP_BEQ: begin c = a - b; f = (a == b); end
      OP_BNE: begin c = a - b; f = (a != b); end
      OP_BLT: begin c = a - b; f = ($signed(a) < $signed(b)); end
      OP_BGE: begin c = a - b; f = ($signed(a) >= $signed(b)); end
      default: ;
    endcase
    return {f, c};
  endfunction

  assign {alu_f_w[0], alu_c_w[0]} = alu_model(alu_op_w[0], alu_a_w[0], alu_b_w[0]);
  assign {alu_f_w[1], alu_c_w[1]} = alu_model(alu_op_w[1], alu_a_w[1], alu_b_w[1]);

  alu_issue #(.EXEC_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready_w[0]),
    .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]), .alu_op(alu_op_w[0]),
    .alu_c(alu_c_w[0]), .alu_f(alu_f_w[0]),
    .res_valid(res_valid_w[0]), .res_ready(res_ready), .res_data(res_data_w[0]),
    .res_rd(res_rd_w[0]), .res_we(res_we_w[0]), .res_taken(res_taken_w[0]),
    .res_illegal(res_illegal_w[0]), .retire_cnt(retire_w[0])
  );

  alu_issue #(.EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready_w[1]),
    .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]), .alu_op(alu_op_w[1]),
    .alu_c(alu_c_w[1]), .alu_f(alu_f_w[1]),
    .res_valid(res_valid_w[1]), .res_ready(res_ready), .res_data(res_data_w[1]),
    .res_rd(res_rd_w[1]), .res_we(res_we_w[1]), .res_taken(res_taken_w[1]),
    .res_illegal(res_illegal_w[1]), .retire_cnt(retire_w[1])
  );

  // Instruction-level semantics: what the instruction means, not how it is decoded.
  function automatic exp_t ref_exec(input logic [31:0] w, input logic [31:0] r1,
                                    input logic [31:0] r2);
    exp_t        e;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [2:0]  f3;
    logic [6:0]  f7;
    e   = '0;
    e.rd = w[11:7];
    imm = {{20{w[31]}}, w[31:20]};
    sh  = w[24:20];
    f3  = w[14:12];
    f7  = w[31:25];
    e.legal = 1'b1;
    case (w[6:0])
      7'h33: begin
        e.a = r1; e.b = r2;
        if      (f7 == 7'h00 && f3 == 3'd0) begin e.op = OP_ADD; e.data = r1 + r2; end
        else if (f7 == 7'h20 && f3 == 3'd0) begin e.op = OP_SUB; e.data = r1 - r2; end
        else if (f7 == 7'h00 && f3 == 3'd7) begin e.op = OP_AND; e.data = r1 & r2; end
        else if (f7 == 7'h00 && f3 == 3'd6) begin e.op = OP_OR;  e.data = r1 | r2; end
        else if (f7 == 7'h00 && f3 == 3'd4) begin e.op = OP_XOR; e.data = r1 ^ r2; end
        else if (f7 == 7'h00 && f3 == 3'd1) begin e.op = OP_SLL; e.data = r1 << r2[4:0]; end
        else if (f7 == 7'h00 && f3 == 3'd5) begin e.op = OP_SLR; e.data = r1 >> r2[4:0]; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin
          e.op = OP_SAR; e.data = $signed(r1) >>> r2[4:0];
        end
        else e.legal = 1'b0;
      end
      7'h13: begin
        e.a = r1; e.b = imm;
        if      (f3 == 3'd0) begin e.op = OP_ADD; e.data = r1 + imm; end
        else if (f3 == 3'd7) begin e.op = OP_AND; e.data = r1 & imm; end
        else if (f3 == 3'd6) begin e.op = OP_OR;  e.data = r1 | imm; end
        else if (f3 == 3'd4) begin e.op = OP_XOR; e.data = r1 ^ imm; end
        else if (f3 == 3'd1 && f7 == 7'h00) begin
          e.op = OP_SLL; e.b = {27'b0, sh}; e.data = r1 << sh;
        end
        else if (f3 == 3'd5 && f7 == 7'h00) begin
          e.op = OP_SLR; e.b = {27'b0, sh}; e.data = r1 >> sh;
        end
        else if (f3 == 3'd5 && f7 == 7'h20) begin
          e.op = OP_SAR; e.b = {27'b0, sh}; e.data = $signed(r1) >>> sh;
        end
        else e.legal = 1'b0;
      end
      7'h37: begin
        e.op = OP_ADD; e.a = 32'd0; e.b = {w[31:12], 12'b0}; e.data = {w[31:12], 12'b0};
      end
      7'h63: begin
        e.a = r1; e.b = r2; e.branch = 1'b1;
        if      (f3 == 3'd0) begin e.op = OP_BEQ; e.taken = (r1 == r2); end
        else if (f3 == 3'd1) begin e.op = OP_BNE; e.taken = (r1 != r2); end
        else if (f3 == 3'd4) begin e.op = OP_BLT; e.taken = ($signed(r1) < $signed(r2)); end
        else if (f3 == 3'd5) begin e.op = OP_BGE; e.taken = ($signed(r1) >= $signed(r2)); end
        else e.legal = 1'b0;
      end
      default: e.legal = 1'b0;
    endcase
    if (!e.legal) begin
      e.branch = 1'b0; e.op = 4'd0; e.a = 32'd0; e.b = 32'd0; e.data = 32'd0; e.taken = 1'b0;
    end
    e.we = e.legal && !e.branch && (e.rd != 5'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int exec_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk_alu_zero(input string tag, input int d);
    chk($sformatf("%s_alu_a_d%0d", tag, d), alu_a_w[d], 32'd0);
    chk($sformatf("%s_alu_b_d%0d", tag, d), alu_b_w[d], 32'd0);
    chk($sformatf("%s_alu_op_d%0d", tag, d), {28'd0, alu_op_w[d]}, 32'd0);
  endtask

  // One full transaction on both DUTs; result is held back for `hold` extra cycles.
  task automatic run_txn(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2,
                         input int hold);
    exp_t e;
    int   first_hold[2];
    int   tmax;
    e = ref_exec(w, r1, r2);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("ready_pre_d%0d", d), {31'd0, inst_ready_w[d]}, 32'd1);
    inst_valid = 1'b1; inst = w; rs1_data = r1; rs2_data = r2;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) first_hold[d] = e.legal ? exec_of(d) + 1 : 1;
    tmax = ((first_hold[0] > first_hold[1]) ? first_hold[0] : first_hold[1]) + hold;
    for (int c = 1; c <= tmax; c++) begin
      inst_valid = 1'($urandom_range(0, 1));
      inst = $urandom; rs1_data = $urandom; rs2_data = $urandom;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy_ready_d%0d_c%0d", d, c), {31'd0, inst_ready_w[d]}, 32'd0);
        if (c < first_hold[d]) begin
          chk($sformatf("exec_valid_d%0d_c%0d", d, c), {31'd0, res_valid_w[d]}, 32'd0);
          chk($sformatf("exec_a_d%0d_c%0d", d, c), alu_a_w[d], e.a);
          chk($sformatf("exec_b_d%0d_c%0d", d, c), alu_b_w[d], e.b);
          chk($sformatf("exec_op_d%0d_c%0d", d, c), {28'd0, alu_op_w[d]}, {28'd0, e.op});
        end else begin
          chk($sformatf("hold_valid_d%0d_c%0d", d, c), {31'd0, res_valid_w[d]}, 32'd1);
          chk_alu_zero("hold", d);
          chk($sformatf("hold_data_d%0d", d), res_data_w[d], e.data);
          chk($sformatf("hold_rd_d%0d", d), {27'd0, res_rd_w[d]}, {27'd0, e.rd});
          chk($sformatf("hold_we_d%0d", d), {31'd0, res_we_w[d]}, {31'd0, e.we});
          chk($sformatf("hold_taken_d%0d", d), {31'd0, res_taken_w[d]}, {31'd0, e.taken});
          chk($sformatf("hold_illegal_d%0d", d), {31'd0, res_illegal_w[d]}, {31'd0, !e.legal});
        end
      end
    end
    inst_valid = 1'b0;
    res_ready  = 1'b1;
    @(posedge clk);
    exp_retire = exp_retire + 32'd1;
    @(negedge clk);
    res_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("post_ready_d%0d", d), {31'd0, inst_ready_w[d]}, 32'd1);
      chk($sformatf("post_valid_d%0d", d), {31'd0, res_valid_w[d]}, 32'd0);
      chk($sformatf("post_retire_d%0d", d), retire_w[d], exp_retire);
      chk_alu_zero("post", d);
    end
  endtask

  function automatic logic [31:0] gen_inst();
    logic [4:0]  rd, ra, rb;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          sel;
    rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    ra  = 5'($urandom);
    rb  = 5'($urandom);
    f3  = 3'($urandom);
    sel = $urandom_range(0, 3);
    f7  = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : (sel == 2) ? 7'h00 : 7'($urandom);
    case ($urandom_range(0, 5))
      0, 5:    return {f7, rb, ra, f3, rd, 7'h33};
      1:       return {f7, rb, ra, f3, rd, 7'h13};
      2:       return {20'($urandom), rd, 7'h37};
      3:       return {7'($urandom), rb, ra, f3, rd, 7'h63};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, r1, r2;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready_d%0d", d), {31'd0, inst_ready_w[d]}, 32'd0);
      chk($sformatf("rst_valid_d%0d", d), {31'd0, res_valid_w[d]}, 32'd0);
      chk($sformatf("rst_data_d%0d", d), res_data_w[d], 32'd0);
      chk($sformatf("rst_flags_d%0d", d),
          {24'd0, res_rd_w[d], res_we_w[d], res_taken_w[d], res_illegal_w[d]}, 32'd0);
      chk($sformatf("rst_retire_d%0d", d), retire_w[d], 32'd0);
      chk_alu_zero("rst", d);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("rel_ready_d%0d", d), {31'd0, inst_ready_w[d]}, 32'd1);

    run_txn(32'hFFF0_8293, 32'd5, 32'd0, 0);                                     // addi x5,x1,-1
    run_txn({7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'h63}, 32'd7, 32'd7, 0);          // beq
    run_txn({7'h00, 5'd2, 5'd1, 3'b001, 5'd0, 7'h63}, 32'd7, 32'd7, 0);          // bne
    run_txn({7'h20, 5'd2, 5'd1, 3'b101, 5'd3, 7'h33}, 32'h8000_0000, 32'd4, 0);  // sra
    run_txn({7'h00, 5'd2, 5'd1, 3'b000, 5'd9, 7'h33}, 32'd100, 32'd23, 10);      // add, backpressure
    run_txn(32'hFFFF_FFFF, 32'd1, 32'd2, 1);                                     // illegal
    run_txn({20'hABCDE, 5'd4, 7'h37}, 32'd1, 32'd2, 0);                          // lui
    run_txn({7'h00, 5'd2, 5'd1, 3'b010, 5'd4, 7'h33}, 32'd1, 32'd2, 0);          // slt is illegal

    for (int n = 0; n < 40; n++) begin
      w  = gen_inst();
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      run_txn(w, r1, r2, $urandom_range(0, 2));
    end

    @(negedge clk);
    inst_valid = 1'b1;
    inst = {7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33};
    rs1_data = 32'd50; rs2_data = 32'd8;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    @(negedge clk);
    chk("mid_exec_op_d1", {28'd0, alu_op_w[1]}, {28'd0, OP_SUB});
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midrst_valid_d%0d", d), {31'd0, res_valid_w[d]}, 32'd0);
      chk($sformatf("midrst_ready_d%0d", d), {31'd0, inst_ready_w[d]}, 32'd0);
      chk($sformatf("midrst_retire_d%0d", d), retire_w[d], 32'd0);
      chk_alu_zero("midrst", d);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_retire = 32'd0;
    repeat (6) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("afterrst_valid_d%0d", d), {31'd0, res_valid_w[d]}, 32'd0);
        chk($sformatf("afterrst_ready_d%0d", d), {31'd0, inst_ready_w[d]}, 32'd1);
        chk_alu_zero("afterrst", d);
      end
    end

    @(negedge clk);
    force u_dut1.retire_cnt_q = 32'hFFFF_FFFF;
    force u_dut3.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_dut1.retire_cnt_q;
    release u_dut3.retire_cnt_q;
    exp_retire = 32'hFFFF_FFFF;
    run_txn({12'h007, 5'd1, 3'b000, 5'd6, 7'h13}, 32'd1, 32'd0, 0);              // addi, wraps count

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
